// File: rtl/line_cmd_issuer.sv
// line_cmd_issuer: buffers CPU line commands in a 2-entry FIFO and plays each one to the line engine as strobed phases.
// Optional macro COLOR_CACHE_EN skips the COLOR phase when the color repeats the last one sent.
module line_cmd_issuer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_x0,
    input  logic [9:0]  cmd_y0,
    input  logic [9:0]  cmd_x1,
    input  logic [9:0]  cmd_y1,
    input  logic [31:0] cmd_color,
    input  logic        LE_ready,
    output logic [9:0]  LE_point,
    output logic [31:0] LE_color,
    output logic        LE_color_valid,
    output logic        LE_x0_valid,
    output logic        LE_y0_valid,
    output logic        LE_x1_valid,
    output logic        LE_y1_valid,
    output logic        LE_trigger,
    output logic        busy,
    output logic [15:0] lines_issued
);
    typedef enum logic [3:0] {IDLE, WAIT_RDY, COLOR, X0, Y0, X1, Y1T, GAP, DONE_WAIT} state_t;
    state_t      state_q, state_d;
    logic [71:0] fifo_q [2];
    logic [71:0] work_q, work_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] lines_issued_q, lines_issued_d;
    logic        wr_q, rd_q, push, pop, skip_color;
    assign cmd_ready      = cnt_q != 2'd2;
    assign push           = cmd_valid && cmd_ready;
    assign pop            = state_q == IDLE && cnt_q != 2'd0;
    assign cnt_d          = cnt_q + {1'b0, push} - {1'b0, pop};
    assign work_d         = pop ? fifo_q[rd_q] : work_q;
    assign lines_issued_d = lines_issued_q + {15'd0, state_q == Y1T};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= 2'd0;
            wr_q           <= 1'b0;
            rd_q           <= 1'b0;
            work_q         <= '0;
            lines_issued_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wr_q           <= wr_q ^ push;
            rd_q           <= rd_q ^ pop;
            work_q         <= work_d;
            lines_issued_q <= lines_issued_d;
        end
    end
    // Entry layout {x0,y0,x1,y1,color}; occupancy is tracked by cnt_q so data needs no reset.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_q] <= {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color};
    end
`ifdef COLOR_CACHE_EN
    logic [31:0] last_color_q;
    logic        last_valid_q;
    assign skip_color = last_valid_q && last_color_q == work_q[31:0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_color_q <= '0;
            last_valid_q <= 1'b0;
        end else if (state_q == Y1T) begin
            last_color_q <= work_q[31:0];
            last_valid_q <= 1'b1;
        end
    end
`else
    assign skip_color = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = pop ? WAIT_RDY : IDLE;
            WAIT_RDY:  state_d = LE_ready ? (skip_color ? X0 : COLOR) : WAIT_RDY;
            COLOR:     state_d = X0;
            X0:        state_d = Y0;
            Y0:        state_d = X1;
            X1:        state_d = Y1T;
            Y1T:       state_d = GAP;
            GAP:       state_d = DONE_WAIT;
            DONE_WAIT: state_d = LE_ready ? IDLE : DONE_WAIT;
            default:   state_d = IDLE;
        endcase
    end
    assign LE_color_valid = state_q == COLOR;
    assign LE_x0_valid    = state_q == X0;
    assign LE_y0_valid    = state_q == Y0;
    assign LE_x1_valid    = state_q == X1;
    assign LE_y1_valid    = state_q == Y1T;
    assign LE_trigger     = state_q == Y1T;
    assign LE_point       = state_q == X0  ? work_q[71:62] :
                            state_q == Y0  ? work_q[61:52] :
                            state_q == X1  ? work_q[51:42] :
                            state_q == Y1T ? work_q[41:32] : 10'd0;
    assign LE_color       = work_q[31:0];
    assign busy           = cnt_q != 2'd0 || state_q != IDLE;
    assign lines_issued   = lines_issued_q;
endmodule

// File: tb/tb_line_cmd_issuer.sv
// tb_line_cmd_issuer: directed self-checking bench for line_cmd_issuer.
module tb_line_cmd_issuer;
    logic        clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, cmd_ready, LE_ready = 1'b0;
    logic [9:0]  cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0, LE_point;
    logic [31:0] cmd_color = '0, LE_color;
    logic        LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger, busy;
    logic [15:0] lines_issued;
    logic [5:0]  stb;
    int          checks = 0, errors = 0;

    line_cmd_issuer dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_color(cmd_color),
        .LE_ready(LE_ready), .LE_point(LE_point), .LE_color(LE_color),
        .LE_color_valid(LE_color_valid), .LE_x0_valid(LE_x0_valid), .LE_y0_valid(LE_y0_valid),
        .LE_x1_valid(LE_x1_valid), .LE_y1_valid(LE_y1_valid), .LE_trigger(LE_trigger),
        .busy(busy), .lines_issued(lines_issued)
    );

    assign stb = {LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger};
    always #5 clk = ~clk;

    task automatic push(input logic [9:0] x0, input logic [9:0] y0, input logic [9:0] x1,
                        input logic [9:0] y1, input logic [31:0] c);
        int n;
        n = 0;
        {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color} = {x0, y0, x1, y1, c};
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_accept: cmd_ready=%b required 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_strobe(output int n);
        n = 0;
        while (stb == 6'd0 && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({stb, LE_point, LE_color, busy, lines_issued} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: stb=%b point=%0d color=%h busy=%b lines=%0d required all 0",
                     stb, LE_point, LE_color, busy, lines_issued);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: cmd_ready=%b busy=%b required 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_basic;
        int n;
        logic [5:0] es [5];
        logic [9:0] ep [5];
        es = '{6'b100000, 6'b010000, 6'b001000, 6'b000100, 6'b000011};
        ep = '{10'd0, 10'd0, 10'd0, 10'd799, 10'd599};
        LE_ready = 1'b1;
        push(10'd0, 10'd0, 10'd799, 10'd599, 32'h007F0000);
        wait_strobe(n);
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles required 2", n);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (stb !== es[i] || (i > 0 && LE_point !== ep[i]) || LE_color !== 32'h007F0000) begin
                errors++;
                $display("FAIL basic_phase%0d: stb=%b point=%0d color=%h required stb=%b point=%0d color=007f0000",
                         i, stb, LE_point, LE_color, es[i], ep[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (stb !== 6'd0 || lines_issued !== 16'd1) begin
            errors++;
            $display("FAIL basic_gap: stb=%b lines=%0d required 0 1", stb, lines_issued);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_back_to_back;
        int t[$];
        logic [9:0] xs[$];
        logic bad;
        LE_ready = 1'b0;
        push(10'd10, 10'd11, 10'd12, 10'd13, 32'h00010101);
        push(10'd20, 10'd21, 10'd22, 10'd23, 32'h00020202);
        push(10'd30, 10'd31, 10'd32, 10'd33, 32'h00030303);
        checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_full: cmd_ready=%b busy=%b required 0 1", cmd_ready, busy);
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (stb !== 6'd0 || cmd_ready !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL b2b_hold: strobe or cmd_ready seen while LE_ready=0, required none");
        end
        LE_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (LE_x0_valid) xs.push_back(LE_point);
            if (LE_trigger) t.push_back(c);
            @(negedge clk);
        end
        checks++;
        if (t.size() != 3 || xs.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: triggers=%0d x0s=%0d required 3 3", t.size(), xs.size());
        end else begin
            checks++;
            if (xs[0] !== 10'd10 || xs[1] !== 10'd20 || xs[2] !== 10'd30) begin
                errors++;
                $display("FAIL b2b_order: x0=%0d,%0d,%0d required 10,20,30", xs[0], xs[1], xs[2]);
            end
            checks++;
            if (t[1] - t[0] != 9 || t[2] - t[1] != 9) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d,%0d required 9,9", t[1] - t[0], t[2] - t[1]);
            end
        end
        checks++;
        if (lines_issued !== 16'd4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_lines: lines=%0d busy=%b required 4 0", lines_issued, busy);
        end
    endtask

    task automatic test_done_wait;
        int n;
        logic bad;
        LE_ready = 1'b1;
        push(10'd100, 10'd101, 10'd102, 10'd103, 32'h00040404);
        push(10'd200, 10'd201, 10'd202, 10'd203, 32'h00050505);
        n = 0;
        while (!LE_trigger && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (LE_trigger !== 1'b1) begin
            errors++;
            $display("FAIL dw_trigger: trigger=%b required 1", LE_trigger);
        end
        LE_ready = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (stb !== 6'd0 || busy !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL dw_hold: strobe or busy=0 seen in DONE_WAIT, required no strobe and busy=1");
        end
        LE_ready = 1'b1;
        wait_strobe(n);
        checks++;
        if (n !== 3 || stb !== 6'b100000) begin
            errors++;
            $display("FAIL dw_resume: got %0d cycles stb=%b required 3 100000", n, stb);
        end
        @(negedge clk);
        checks++;
        if (LE_x0_valid !== 1'b1 || LE_point !== 10'd200) begin
            errors++;
            $display("FAIL dw_next_x0: x0_valid=%b point=%0d required 1 200", LE_x0_valid, LE_point);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (lines_issued !== 16'd6 || busy !== 1'b0) begin
            errors++;
            $display("FAIL dw_lines: lines=%0d busy=%b required 6 0", lines_issued, busy);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        logic bad;
        LE_ready = 1'b1;
        push(10'd300, 10'd301, 10'd302, 10'd303, 32'h00060606);
        push(10'd310, 10'd311, 10'd312, 10'd313, 32'h00070707);
        n = 0;
        while (!LE_x1_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (LE_x1_valid !== 1'b1 || LE_point !== 10'd302) begin
            errors++;
            $display("FAIL rst_mid_x1: x1_valid=%b point=%0d required 1 302", LE_x1_valid, LE_point);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({stb, LE_point, LE_color, lines_issued, busy} !== '0) begin
            errors++;
            $display("FAIL rst_mid_async: stb=%b point=%0d color=%h lines=%0d busy=%b required all 0",
                     stb, LE_point, LE_color, lines_issued, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (stb !== 6'd0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rst_mid_quiet: strobe or busy after reset release, required none");
        end
        push(10'd400, 10'd401, 10'd402, 10'd403, 32'h00123456);
        wait_strobe(n);
        checks++;
        if (n !== 2 || stb !== 6'b100000 || LE_color !== 32'h00123456) begin
            errors++;
            $display("FAIL rst_mid_new: got %0d cycles stb=%b color=%h required 2 100000 00123456", n, stb, LE_color);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (lines_issued !== 16'd1) begin
            errors++;
            $display("FAIL rst_mid_lines: lines=%0d required 1", lines_issued);
        end
    endtask

    task automatic test_color_cache;
        logic [2:0] seen_v, exp_v;
        logic seen;
        int k;
`ifdef COLOR_CACHE_EN
        exp_v = 3'b101;
`else
        exp_v = 3'b111;
`endif
        LE_ready = 1'b0;
        push(10'd1, 10'd1, 10'd1, 10'd1, 32'h00FF0000);
        push(10'd2, 10'd2, 10'd2, 10'd2, 32'h00FF0000);
        push(10'd3, 10'd3, 10'd3, 10'd3, 32'h0000FF00);
        LE_ready = 1'b1;
        seen = 1'b0;
        seen_v = 3'b000;
        k = 0;
        for (int c = 0; c < 60; c++) begin
            if (LE_color_valid) seen = 1'b1;
            if (LE_trigger) begin
                if (k < 3) seen_v[2 - k] = seen;
                k++;
                seen = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (k != 3 || seen_v !== exp_v) begin
            errors++;
            $display("FAIL color_cache: lines=%0d color_phases=%b required 3 %b", k, seen_v, exp_v);
        end
        checks++;
        if (lines_issued !== 16'd4) begin
            errors++;
            $display("FAIL color_cache_lines: lines=%0d required 4", lines_issued);
        end
    endtask

    task automatic test_wrap;
        int n;
        force dut.lines_issued_q = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.lines_issued_q;
        @(negedge clk);
        checks++;
        if (lines_issued !== 16'hFFFE) begin
            errors++;
            $display("FAIL wrap_preload: lines=%h required fffe", lines_issued);
        end
        for (int j = 0; j < 2; j++) begin
            push(10'd5, 10'd6, 10'd7, 10'd8, 32'h00ABCDEF);
            n = 0;
            while (!LE_trigger && n < 30) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
            checks++;
            if (lines_issued !== (j == 0 ? 16'hFFFF : 16'h0000)) begin
                errors++;
                $display("FAIL wrap_step%0d: lines=%h required %h", j, lines_issued, j == 0 ? 16'hFFFF : 16'h0000);
            end
            repeat (3) @(negedge clk);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_done_wait;
        test_reset_mid;
        test_color_cache;
        test_wrap;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
